seq_det_stream_ctrl: RTL and testbench

//  Controller that feeds a serial pattern detector (e.g. 101101 Mealy detector) from a

---
 rtl/seq_det_stream_ctrl.sv | 150 +++++++++++++++
 tb/tb_seq_det_stream_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-serial feeder for a bit-serial pattern detector. Words are shifted out MSB-first with
// programmable idle gaps, and detector hits are counted per word and in total.
module seq_det_stream_ctrl #(
  parameter int WORD_W  = 8,
  parameter int GAP_CYC = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic              det_valid,
  output logic              det_data,
  output logic              det_rst,
  input  logic              det_hit,
  output logic              busy,
  output logic              word_done,
  output logic [CNT_W-1:0]  word_hits,
  output logic [CNT_W-1:0]  total_hits
);

  localparam int IW = $clog2(WORD_W);
  localparam int GW = 4;

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              last_q, last_d;
  logic              hit_win_q, hit_win_d;
  logic              det_valid_q, det_valid_d;
  logic              det_data_q, det_data_d;
  logic              det_rst_q, det_rst_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              word_done_q, word_done_d;
  logic [CNT_W-1:0]  word_hits_q, word_hits_d;
  logic [CNT_W-1:0]  total_hits_q, total_hits_d;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    gap_cnt_d    = gap_cnt_q;
    last_d       = last_q;
    word_hits_d  = word_hits_q;
    total_hits_d = total_hits_q;

    // hit_win_q marks the cycle in which the detector's response to our last bit is visible
    if (hit_win_q && det_hit) begin
      if (word_hits_q != '1)  word_hits_d  = word_hits_q + CNT_W'(1);
      if (total_hits_q != '1) total_hits_d = total_hits_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          shreg_d     = in_data;
          bit_idx_d   = IW'(WORD_W - 1);
          last_d      = 1'b0;
          word_hits_d = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        last_d  = (bit_idx_q == '0);
        if (bit_idx_q != '0) bit_idx_d = bit_idx_q - IW'(1);
        if (GAP_CYC > 0) begin
          state_d   = GAP;
          gap_cnt_d = GW'(GAP_CYC - 1);
        end else if (bit_idx_q == '0) begin
          state_d = DRAIN;
        end else begin
          state_d = SHIFT;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = last_q ? DRAIN : SHIFT;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // clear wins over everything, including a same-edge accept
    if (clear) begin
      state_d      = IDLE;
      word_hits_d  = '0;
      total_hits_d = '0;
    end

    hit_win_d   = det_valid_q && !clear;
    det_valid_d = (state_d == SHIFT);
    det_data_d  = det_valid_d && shreg_d[WORD_W-1];
    det_rst_d   = clear;
    in_ready_d  = (state_d == IDLE) && !clear;
    busy_d      = (state_d != IDLE);
    word_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      gap_cnt_q    <= '0;
      last_q       <= 1'b0;
      hit_win_q    <= 1'b0;
      det_valid_q  <= 1'b0;
      det_data_q   <= 1'b0;
      det_rst_q    <= 1'b1;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
      word_hits_q  <= '0;
      total_hits_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      last_q       <= last_d;
      hit_win_q    <= hit_win_d;
      det_valid_q  <= det_valid_d;
      det_data_q   <= det_data_d;
      det_rst_q    <= det_rst_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
      word_hits_q  <= word_hits_d;
      total_hits_q <= total_hits_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign det_valid  = det_valid_q;
  assign det_data   = det_data_q;
  assign det_rst    = det_rst_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;
  assign word_hits  = word_hits_q;
  assign total_hits = total_hits_q;

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Bench for seq_det_stream_ctrl: unit 0 uses defaults (gap 1, 8-bit counters), unit 1 uses
// gap 0 and 2-bit counters. Each unit drives a behavioural overlapping 101101 Mealy detector.
module tb_seq_det_stream_ctrl;

  typedef struct {
    int         u;
    logic [7:0] w;
    int         hits;
    int         total;
    bit         churn;
  } vec_t;

  typedef struct {
    int hits;
    int total;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      in_valid, clear;
  logic [1:0][7:0] in_data;
  logic [1:0]      in_ready, det_valid, det_data, det_rst, busy, word_done;
  logic            hit0, hit1;
  logic [2:0]      ds0, ds1;
  logic [7:0]      wh0, th0;
  logic [1:0]      wh1, th1;

  int   checks = 0, failures = 0, cyc = 0;
  logic bitq0[$], bitq1[$];
  exp_t wq0[$], wq1[$];
  logic prev_dv0 = 1'b0;
  vec_t tbl[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_stream_ctrl #(.WORD_W(8), .GAP_CYC(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .clear(clear[0]), .det_valid(det_valid[0]), .det_data(det_data[0]), .det_rst(det_rst[0]),
    .det_hit(hit0), .busy(busy[0]), .word_done(word_done[0]), .word_hits(wh0), .total_hits(th0)
  );

  seq_det_stream_ctrl #(.WORD_W(8), .GAP_CYC(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .clear(clear[1]), .det_valid(det_valid[1]), .det_data(det_data[1]), .det_rst(det_rst[1]),
    .det_hit(hit1), .busy(busy[1]), .word_done(word_done[1]), .word_hits(wh1), .total_hits(th1)
  );

  // Overlapping 101101 detector: returns {hit, next_state}
  function automatic logic [3:0] det_step(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 4'd1 : 4'd0;
      3'd1:    return b ? 4'd1 : 4'd2;
      3'd2:    return b ? 4'd3 : 4'd0;
      3'd3:    return b ? 4'd4 : 4'd2;
      3'd4:    return b ? 4'd1 : 4'd5;
      3'd5:    return b ? 4'b1011 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst || det_rst[0]) begin ds0 <= 3'd0; hit0 <= 1'b0; end
    else if (det_valid[0])  {hit0, ds0} <= det_step(ds0, det_data[0]);
    else                    hit0 <= 1'b0;

  always @(posedge clk or negedge rst)
    if (!rst || det_rst[1]) begin ds1 <= 3'd0; hit1 <= 1'b0; end
    else if (det_valid[1])  {hit1, ds1} <= det_step(ds1, det_data[1]);
    else                    hit1 <= 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s act=timeout exp=event", nm);
  endtask

  // Scoreboard side: pop expected bits / word results as the DUTs produce them
  always @(negedge clk) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        logic b;
        exp_t e;
        logic [7:0] whv, thv;
        whv = (u == 0) ? wh0 : {6'b0, wh1};
        thv = (u == 0) ? th0 : {6'b0, th1};
        if (det_valid[u]) begin
          if (u == 0 && bitq0.size() == 0)      tmo("det_bit_unexpected0");
          else if (u == 1 && bitq1.size() == 0) tmo("det_bit_unexpected1");
          else begin
            b = (u == 0) ? bitq0.pop_front() : bitq1.pop_front();
            chk($sformatf("det_data_u%0d", u), 32'(det_data[u]), 32'(b));
          end
        end
        if (word_done[u]) begin
          if (u == 0 && wq0.size() == 0)      chk("word_done_unexpected0", 1, 0);
          else if (u == 1 && wq1.size() == 0) chk("word_done_unexpected1", 1, 0);
          else begin
            e = (u == 0) ? wq0.pop_front() : wq1.pop_front();
            chk($sformatf("word_hits_u%0d", u), 32'(whv), 32'(e.hits));
            chk($sformatf("total_hits_u%0d", u), 32'(thv), 32'(e.total));
          end
        end
      end
      if (det_valid[0]) chk("gap_u0", 32'(prev_dv0), 0);
      prev_dv0 = det_valid[0];
    end
  end

  task automatic push_bits(input int u, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      if (u == 0) bitq0.push_back(w[i]);
      else        bitq1.push_back(w[i]);
    end
  endtask

  task automatic wait_ready(input int u);
    int n;
    n = 0;
    while (!in_ready[u] && n < 100) begin @(negedge clk); n++; end
    if (!in_ready[u]) tmo("in_ready_wait");
  endtask

  task automatic send(input int u, input logic [7:0] w, input int eh, input int et, input bit churn);
    int   n, a;
    exp_t e;
    e.hits = eh;
    e.total = et;
    wait_ready(u);
    push_bits(u, w);
    if (u == 0) wq0.push_back(e);
    else        wq1.push_back(e);
    in_valid[u] = 1'b1;
    in_data[u]  = w;
    @(posedge clk); #1 a = cyc;
    @(negedge clk);
    if (!churn) in_valid[u] = 1'b0;
    n = 0;
    while (!word_done[u] && n < 200) begin
      if (churn) begin
        in_data[u] = 8'($urandom);
        chk("in_ready_busy", 32'(in_ready[u]), 0);
      end
      @(negedge clk); n++;
    end
    if (!word_done[u]) tmo("word_done_wait");
    else chk($sformatf("latency_u%0d", u), 32'(cyc - a + 1), (u == 0) ? 32'd18 : 32'd10);
    @(negedge clk);
    chk("in_ready_after_done", 32'(in_ready[u]), 1);
  endtask

  task automatic wait_bits(input int u, input int nbits);
    int nb, k;
    nb = 0;
    k = 0;
    while (k < 60) begin
      if (det_valid[u]) nb++;
      if (nb == nbits) break;
      @(negedge clk); k++;
    end
    if (nb != nbits) tmo("bit_count_wait");
  endtask

  initial begin
    int seen;
    tbl[0] = '{u:0, w:8'hB6, hits:1, total:1, churn:1'b1};
    tbl[1] = '{u:0, w:8'h80, hits:1, total:2, churn:1'b0};
    tbl[2] = '{u:0, w:8'h2D, hits:1, total:3, churn:1'b0};
    tbl[3] = '{u:0, w:8'h6D, hits:2, total:5, churn:1'b0};
    tbl[4] = '{u:0, w:8'hFF, hits:0, total:5, churn:1'b0};
    tbl[5] = '{u:0, w:8'h00, hits:0, total:5, churn:1'b0};
    tbl[6] = '{u:1, w:8'hB6, hits:1, total:1, churn:1'b0};
    tbl[7] = '{u:1, w:8'hB6, hits:2, total:3, churn:1'b0};
    tbl[8] = '{u:1, w:8'hB6, hits:2, total:3, churn:1'b0};
    tbl[9] = '{u:1, w:8'hB6, hits:2, total:3, churn:1'b0};

    rst = 1'b0;
    in_valid = '0;
    clear = '0;
    in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_det_valid", 32'(det_valid), 0);
    chk("rst_det_data", 32'(det_data), 0);
    chk("rst_det_rst", 32'(det_rst), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_word_done", 32'(word_done), 0);
    chk("rst_hits0", 32'({wh0, th0}), 0);
    chk("rst_hits1", 32'({wh1, th1}), 0);
    rst = 1'b1;
    #1 chk("in_ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_release", 32'(in_ready), 3);
    chk("det_rst_after_release", 32'(det_rst), 0);

    send(0, 8'hB4, 1, 1, 1'b0);

    // clear during the 4th bit of a word
    wait_ready(0);
    push_bits(0, 8'hB4);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hB4;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_bits(0, 4);
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    bitq0.delete();
    chk("clr_busy", 32'(busy[0]), 0);
    chk("clr_det_valid", 32'(det_valid[0]), 0);
    chk("clr_det_rst", 32'(det_rst[0]), 1);
    chk("clr_in_ready", 32'(in_ready[0]), 0);
    chk("clr_word_hits", 32'(wh0), 0);
    chk("clr_total_hits", 32'(th0), 0);
    @(negedge clk);
    chk("clr_det_rst_pulse", 32'(det_rst[0]), 0);
    chk("clr_in_ready_back", 32'(in_ready[0]), 1);
    seen = 0;
    repeat (20) begin @(negedge clk); if (word_done[0]) seen++; end
    chk("clr_no_word_done", 32'(seen), 0);

    // clear and in_valid on the same edge: word dropped
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hFF;
    clear[0]    = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    clear[0]    = 1'b0;
    chk("clr_accept_busy", 32'(busy[0]), 0);
    chk("clr_accept_in_ready", 32'(in_ready[0]), 0);
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      send(tbl[i].u, tbl[i].w, tbl[i].hits, tbl[i].total, tbl[i].churn);
    chk("sat_total_hold", 32'(th1), 3);
    chk("u0_no_pending", 32'(wq0.size() + wq1.size()), 0);

    // asynchronous reset in the middle of a SHIFT on the gap-0 unit
    wait_ready(1);
    push_bits(1, 8'hB6);
    in_valid[1] = 1'b1;
    in_data[1]  = 8'hB6;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    wait_bits(1, 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_det_valid", 32'(det_valid[1]), 0);
    chk("arst_busy", 32'(busy[1]), 0);
    chk("arst_det_rst", 32'(det_rst[1]), 1);
    chk("arst_in_ready", 32'(in_ready[1]), 0);
    chk("arst_hits", 32'({wh1, th1}), 0);
    bitq1.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_in_ready_back", 32'(in_ready[1]), 1);
    seen = 0;
    repeat (15) begin @(negedge clk); if (word_done[1] || busy[1]) seen++; end
    chk("arst_no_word_done", 32'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
